// File: rtl/key_expand_ctrl_if.sv
// -----------------------------------------------------------------------------
// key_expand_ctrl_if
//   Bundles the three faces of the AES-128 key-expansion sequencer:
//     * key-load request   : start, cipher_key  -> busy, done, keys_valid
//     * round-key read port: rd_round           -> rd_key
//     * generator link     : gen_round, gen_in_key -> gen_out_key
//
//   Request semantics: start is a single-cycle request that is accepted only
//   on an edge where the sequencer is idle (busy=0). A start seen while busy
//   is dropped, never queued. cipher_key only needs to be valid on the
//   accepting edge. done pulses for one cycle when the last round key is
//   stored; keys_valid then stays high until the next accepted start.
//
//   Modports:
//     slave  - the sequencer (key_expand_ctrl)
//     master - the environment: key loader, cipher core and round generator
// -----------------------------------------------------------------------------
interface key_expand_ctrl_if;
  logic         start;
  logic [127:0] cipher_key;
  logic         busy;
  logic         done;
  logic         keys_valid;
  logic [3:0]   rd_round;
  logic [127:0] rd_key;
  logic [3:0]   gen_round;
  logic [127:0] gen_in_key;
  logic [127:0] gen_out_key;

  modport slave (
    input  start, cipher_key, rd_round, gen_out_key,
    output busy, done, keys_valid, rd_key, gen_round, gen_in_key
  );

  modport master (
    output start, cipher_key, rd_round, gen_out_key,
    input  busy, done, keys_valid, rd_key, gen_round, gen_in_key
  );
endinterface

// File: rtl/key_expand_ctrl.sv
// -----------------------------------------------------------------------------
// key_expand_ctrl
//   Sequencer for the AES-128 round-key generator. On an accepted start it
//   latches the cipher key into store entry 0, then walks the external
//   generator through rounds 0..NR-1. Each round waits SBOX_LAT cycles for
//   the generator output to settle (WAIT) and then captures it (CAPT) into
//   store entry round+1, so one round costs SBOX_LAT+1 cycles.
//
// Parameters:
//   NR       - number of generated round keys (store depth NR+1)
//   SBOX_LAT - generator latency in cycles from stable inputs to valid output
//
// Ports:
//   clk      - system clock, rising edge
//   rst_n    - asynchronous active-low reset; clears FSM, outputs and store
//   kif      - key_expand_ctrl_if.slave (load request, read port, generator)
//   state_o  - current FSM state (0=IDLE, 1=WAIT, 2=CAPT) for observation
// -----------------------------------------------------------------------------
module key_expand_ctrl #(
  parameter int NR       = 10,
  parameter int SBOX_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  key_expand_ctrl_if.slave    kif,
  output logic [1:0]          state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_CAPT = 2'd2
  } state_e;

  // A one-bit counter is kept even for SBOX_LAT=1 so the width never
  // collapses to zero; its reload value is then simply 0.
  localparam int                WAIT_W     = (SBOX_LAT > 1) ? $clog2(SBOX_LAT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_INIT  = WAIT_W'(SBOX_LAT - 1);
  localparam logic [3:0]        LAST_ROUND = 4'(NR - 1);
  localparam logic [3:0]        MAX_IDX    = 4'(NR);

  state_e            state_q;
  logic [3:0]        round_q;
  logic [WAIT_W-1:0] wait_q;
  logic [127:0]      cur_key_q;
  logic              busy_q;
  logic              done_q;
  logic              keys_valid_q;
  logic [127:0]      store_q [NR+1];

  // Store slot written by the current CAPT.
  logic [3:0]        capt_idx_d;
  assign capt_idx_d = round_q + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      round_q      <= '0;
      wait_q       <= '0;
      cur_key_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      keys_valid_q <= 1'b0;
      for (int i = 0; i <= NR; i++) begin
        store_q[i] <= '0;
      end
    end else begin
      // done is a single-cycle pulse; only the final CAPT raises it.
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (kif.start) begin
            store_q[0]   <= kif.cipher_key;
            cur_key_q    <= kif.cipher_key;
            round_q      <= '0;
            wait_q       <= WAIT_INIT;
            busy_q       <= 1'b1;
            keys_valid_q <= 1'b0;
            state_q      <= S_WAIT;
          end
        end

        // Generator inputs are held by cur_key_q/round_q; just let the
        // pipeline settle for exactly SBOX_LAT cycles.
        S_WAIT: begin
          if (wait_q == '0) begin
            state_q <= S_CAPT;
          end else begin
            wait_q <= wait_q - WAIT_W'(1);
          end
        end

        S_CAPT: begin
          store_q[capt_idx_d] <= kif.gen_out_key;
          cur_key_q           <= kif.gen_out_key;
          if (round_q == LAST_ROUND) begin
            busy_q       <= 1'b0;
            keys_valid_q <= 1'b1;
            done_q       <= 1'b1;
            state_q      <= S_IDLE;
          end else begin
            round_q <= round_q + 4'd1;
            wait_q  <= WAIT_INIT;
            state_q <= S_WAIT;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Random-access read; indices past the last round key read as zero.
  always_comb begin
    kif.rd_key = '0;
    if (kif.rd_round <= MAX_IDX) begin
      kif.rd_key = store_q[kif.rd_round];
    end
  end

  assign kif.gen_in_key = cur_key_q;
  assign kif.gen_round  = round_q;
  assign kif.busy       = busy_q;
  assign kif.done       = done_q;
  assign kif.keys_valid = keys_valid_q;
  assign state_o        = state_q;

endmodule
